// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_seq_pkg: shared state encoding and BCD constants for the sequential double-dabble converter
package bin_to_bcd_seq_pkg;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
endpackage

// File: rtl/bin_to_bcd_seq_add3_digit.sv
// bcd_add3_digit: double-dabble digit correction (adds 3 when digit >= 5); ports: digit in, adjusted out
module bcd_add3_digit
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);
  assign adjusted = digit >= ADD3_THRESH ? digit + 4'd3 : digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter, one shift per clock, saturating output
// ports: clk, reset_n (sync, active-low), start/bin_in request, busy, done pulse, bcd digits, overflow flag
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W = 20,
  parameter int DIGITS = 6,
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);
  localparam int SW = 4*(DIGITS+1);
  state_t             state;
  logic [BIN_W-1:0]   sh;
  logic [SW-1:0]      scr;
  logic [CNT_W-1:0]   cnt;
  logic [SW-1:0]      adj;
  logic [SW+BIN_W-1:0] cat;
  logic [SW-1:0]      nscr;
  logic [BIN_W-1:0]   nsh;
  logic               ovf;
  genvar d;
  generate
    for (d = 0; d <= DIGITS; d++) begin : g_add3
      bcd_add3_digit u_add3 (.digit(scr[4*d +: 4]), .adjusted(adj[4*d +: 4]));
    end
  endgenerate
  always_comb begin
    cat  = {adj, sh} << 1;
    nscr = cat[SW+BIN_W-1:BIN_W];
    nsh  = cat[BIN_W-1:0];
    // the guard digit catches any value too large for DIGITS digits
    ovf  = |nscr[SW-1:4*DIGITS];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      sh       <= '0;
      scr      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          sh    <= bin_in;
          scr   <= '0;
          cnt   <= '0;
          state <= ST_SHIFT;
          busy  <= 1'b1;
        end
      end else begin
        sh  <= nsh;
        scr <= nscr;
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(BIN_W-1)) begin
          bcd      <= ovf ? {DIGITS{BCD_NINE}} : nscr[4*DIGITS-1:0];
          overflow <= ovf;
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: self-checking bench for bin_to_bcd_seq (vector table, corner sequences, random sweep)
module tb_bin_to_bcd_seq;
  localparam int BIN_W = 20;
  localparam int DIGITS = 6;
  localparam int LAT = BIN_W;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic busy, done, overflow;
  logic [4*DIGITS-1:0] bcd;
  int errors = 0;
  int checks = 0;
  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {
    int           val;
    logic [23:0]  exp_bcd;
    logic         exp_ovf;
  } vec_t;
  vec_t vecs[8];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [23:0] ref_bcd(input int v);
    logic [23:0] r;
    int x;
    r = '0;
    x = v;
    if (v > 999999) return 24'h999999;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 60) begin
      if (busy) nb++;
      tick();
      n++;
    end
  endtask
  task automatic run(input int v, input logic [23:0] eb, input logic eo, input string nm);
    int n, nb;
    bin_in = BIN_W'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    bin_in = BIN_W'($urandom);
    wait_done(n, nb);
    chk({nm, "_latency"}, n, LAT);
    chk({nm, "_busy_cycles"}, nb, LAT);
    chk({nm, "_bcd"}, bcd, eb);
    chk({nm, "_ovf"}, overflow, eo);
    chk({nm, "_busy_at_done"}, busy, 0);
    tick();
    chk({nm, "_done_one_cycle"}, done, 0);
  endtask
  initial begin
    int n, nb, ndone, got, m_cnt, cyc;
    int cap;
    logic exp_done;
    vecs[0] = '{123456, 24'h123456, 1'b0};
    vecs[1] = '{999999, 24'h999999, 1'b0};
    vecs[2] = '{1000000, 24'h999999, 1'b1};
    vecs[3] = '{1048575, 24'h999999, 1'b1};
    vecs[4] = '{0, 24'h000000, 1'b0};
    vecs[5] = '{1, 24'h000001, 1'b0};
    vecs[6] = '{90817, 24'h090817, 1'b0};
    vecs[7] = '{500000, 24'h500000, 1'b0};
    reset_n = 1'b0;
    start = 1'b1;
    bin_in = 20'd777;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    start = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outputs", {busy, done, overflow, bcd}, 0);
    end
    for (int i = 0; i < 8; i++)
      run(vecs[i].val, vecs[i].exp_bcd, vecs[i].exp_ovf, $sformatf("vec%0d", i));
    bin_in = 20'd42;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    bin_in = 20'd777;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    chk("ignored_start_latency", n + 5, LAT);
    chk("ignored_start_bcd", bcd, 24'h000042);
    bin_in = 20'd777;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    chk("b2b_latency", n, LAT);
    chk("b2b_bcd", bcd, 24'h000777);
    tick();
    bin_in = 20'd500000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd, 0);
    chk("abort_done", done, 0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0);
    run(9, 24'h000009, 1'b0, "after_abort");
    start = 1'b1;
    m_cnt = 0;
    got = 0;
    cyc = 0;
    cap = 0;
    while (got < 2000 && cyc < 2000 * (LAT + 1) + 100) begin
      bin_in = (got < 4) ? BIN_W'(got == 0 ? 999999 : got == 1 ? 1000000 : got == 2 ? 0 : 1048575)
                         : BIN_W'($urandom_range(0, 1048575));
      exp_done = 1'b0;
      if (m_cnt == 0) begin
        cap = int'(bin_in);
        m_cnt = LAT;
      end else begin
        m_cnt--;
        exp_done = (m_cnt == 0);
      end
      tick();
      cyc++;
      if (exp_done || done) begin
        chk("sweep_done_timing", done, exp_done);
        if (exp_done) begin
          got++;
          chk("sweep_bcd", bcd, ref_bcd(cap));
          chk("sweep_ovf", overflow, cap > 999999);
        end
      end
    end
    chk("sweep_count", got, 2000);
    start = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
